// File: rtl/rail_sequencer.sv
// Power-rail sequencer: enables rails in ascending order, each after the previous rail's
// power-good has settled, and powers down in reverse order on request or fault.
module rail_sequencer #(
  parameter int NUM_RAILS     = 4,
  parameter int TIMER_WIDTH   = 16,
  parameter int PG_TIMEOUT    = 1000,
  parameter int SETTLE_CYCLES = 100,
  parameter int OFF_CYCLES    = 100
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] en,
  output logic                 all_good,
  output logic                 fault,
  output logic [2:0]           fault_rail,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ENABLE  = 3'd1,
    S_WAIT_PG = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4,
    S_DISABLE = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] PG_LAST     = TIMER_WIDTH'(PG_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] OFF_LAST    = TIMER_WIDTH'(OFF_CYCLES - 1);
  localparam logic [2:0]             IDX_LAST    = 3'(NUM_RAILS - 1);

  state_t                 state_q, state_d;
  logic [NUM_RAILS-1:0]   en_q, en_d;
  logic [2:0]             idx_q, idx_d;
  logic [TIMER_WIDTH-1:0] tmr_q, tmr_d;
  logic                   fault_q, fault_d;
  logic [2:0]             fault_rail_q, fault_rail_d;
  logic [NUM_RAILS-1:0]   pg_m_q, pg_s_q;

  logic [NUM_RAILS-1:0]   idx_mask, top_mask, loss;
  logic [2:0]             top_rail, loss_rail;
  logic                   pg_idx;

  function automatic logic [TIMER_WIDTH-1:0] sat_inc(input logic [TIMER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Rail selection helpers: current rail, highest enabled rail, lowest rail that lost power-good.
  always_comb begin
    idx_mask  = NUM_RAILS'(1) << idx_q;
    pg_idx    = |(pg_s_q & idx_mask);
    loss      = en_q & ~pg_s_q;
    top_rail  = 3'd0;
    loss_rail = 3'd0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (en_q[i]) top_rail = 3'(i);
    end
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (loss[i]) loss_rail = 3'(i);
    end
    top_mask = NUM_RAILS'(1) << top_rail;
  end

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    case (state_q)
      S_OFF: begin
        en_d = '0;
        if (enable && !fault_q) begin
          idx_d   = 3'd0;
          state_d = S_ENABLE;
        end
      end
      S_ENABLE: begin
        tmr_d = '0;
        if (!enable) begin
          state_d = S_DISABLE;
        end else begin
          en_d    = en_q | idx_mask;
          state_d = S_WAIT_PG;
        end
      end
      S_WAIT_PG: begin
        if (!enable) begin
          tmr_d   = '0;
          state_d = S_DISABLE;
        end else if (pg_idx) begin
          tmr_d   = '0;
          state_d = S_SETTLE;
        end else if (tmr_q >= PG_LAST) begin
          fault_d      = 1'b1;
          fault_rail_d = idx_q;
          tmr_d        = '0;
          state_d      = S_DISABLE;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      S_SETTLE: begin
        if (!enable) begin
          tmr_d   = '0;
          state_d = S_DISABLE;
        end else if (tmr_q >= SETTLE_LAST) begin
          tmr_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_ENABLE;
          end
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      S_RUN: begin
        // A pg loss wins over a simultaneous power-down request so the fault is recorded.
        if (|loss) begin
          fault_d      = 1'b1;
          fault_rail_d = loss_rail;
          tmr_d        = '0;
          state_d      = S_DISABLE;
        end else if (!enable) begin
          tmr_d   = '0;
          state_d = S_DISABLE;
        end
      end
      S_DISABLE: begin
        if (en_q == '0) begin
          tmr_d   = '0;
          state_d = fault_q ? S_FAULT : S_OFF;
        end else begin
          if (tmr_q == '0) en_d = en_q & ~top_mask;
          tmr_d = (tmr_q >= OFF_LAST) ? '0 : sat_inc(tmr_q);
        end
      end
      S_FAULT: begin
        en_d = '0;
        if (!enable) begin
          fault_d      = 1'b0;
          fault_rail_d = 3'd0;
          state_d      = S_OFF;
        end
      end
      default: begin
        en_d    = '0;
        state_d = S_OFF;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_OFF;
      en_q         <= '0;
      idx_q        <= 3'd0;
      tmr_q        <= '0;
      fault_q      <= 1'b0;
      fault_rail_q <= 3'd0;
      pg_m_q       <= '0;
      pg_s_q       <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
      pg_m_q       <= pg;
      pg_s_q       <= pg_m_q;
    end
  end

  assign en         = en_q;
  assign all_good   = (state_q == S_RUN);
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
  assign state      = state_q;

endmodule
